iter_mul: RTL and testbench
===========================

# iter_mul

Parametrised iterative shift-add multiplier for the execute stage's HI/LO unit. It serves both signed (MULT) and unsigned (MULTU) instructions from one datapath. A start/busy/done handshake lets the pipeline stall while the product forms. It replaces a single-cycle combinational array, trading latency for area and timing slack.

## Interface
- `WIDTH`, default 32: operand width; product is 2*WIDTH bits (must be ≥ 2).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when not busy.
- `is_signed`  in  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with `start`.
- `a`  in  WIDTH  multiplicand; sampled with `start`.
- `b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high while iterating.
- `done`  out  1  single-cycle pulse; `hi`/`lo` valid in that cycle.
- `hi`  out  WIDTH  upper half of product.
- `lo`  out  WIDTH  lower half of product.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, with `start`=1:
  - capture the operands.
  - If `is_signed`, replace each negative operand by its magnitude and record the sign flag `neg = a[MSB] ^ b[MSB]`. Otherwise `neg` = 0.
  - Clear the 2*WIDTH accumulator. Load the multiplicand zero-extended to 2*WIDTH.
  - Go to BUSY.
- BUSY, one multiplier bit per cycle:
  - if the multiplier LSB is 1, accumulator += multiplicand.
  - Shift the multiplicand left by 1 and the multiplier right by 1. The accumulator is never shifted.
  - Increment a bit counter of $clog2(WIDTH)+1 bits.
  - After WIDTH cycles, go to DONE.
- Entry to DONE: {hi,lo} = neg ? −acc : acc (2*WIDTH two's-complement negate). Arithmetic is modulo 2^(2*WIDTH).
- DONE: `done`=1 for one cycle.
  - `start`=1 in this cycle is accepted exactly as in IDLE and goes to BUSY.
  - Otherwise go to IDLE.
- `hi`/`lo` hold their last product until the next entry to DONE or reset.
- `start` while in BUSY is ignored; operands are not re-sampled.
- Most-negative operand: magnitude 2^(WIDTH−1) fits in WIDTH unsigned bits, so no special case is needed.
- `rst`=1 in any cycle, including mid-operation:
  - next state is IDLE, with `busy`=0, `done`=0, `hi`=0, `lo`=0, accumulator and counter cleared.
  - The in-flight product is discarded and no `done` is produced for it.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE.
- `start` is sampled at the edge ending cycle 0.
- `busy`=1 in cycles 1..WIDTH; `done`=1 and the result is valid in cycle WIDTH+1.
- Latency is WIDTH+1 cycles from the `start` edge to `done`; 33 for WIDTH=32.
- Back-to-back: a `start` in the DONE cycle gives the next `done` WIDTH+1 cycles later. Throughput is one product per WIDTH+1 cycles.
- `busy` and `done` are registered; they are never high together.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - in BUSY, if the multiplier remaining after this cycle's shift is zero, go to DONE next regardless of the counter.
  - Latency becomes (index of highest set bit of |b|)+2 cycles, minimum 2 (b=0 or b=1: one BUSY cycle, `done` in cycle 2).
  - The result is identical because the accumulator is unshifted.
- `MUL_EARLY_EXIT_EN` undefined: latency is fixed at WIDTH+1 and the early-exit comparator is absent.

## Test plan
- WIDTH=32, unsigned, a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` in cycle 33, hi=0xFFFFFFFE, lo=0x00000001; `busy` high in cycles 1..32.
- Signed, a=0xFFFFFFFF (−1), b=0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. Signed a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. Unsigned a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- Signed, a=7, b=0xFFFFFFFD (−3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. A second `start` (a=2, b=3, unsigned) in the DONE cycle -> next `done` 33 cycles later with hi=0, lo=6.
- `start` with new operands pulsed in cycle 10 of BUSY -> ignored; the original product is delivered in cycle 33. `rst` in cycle 15 -> cycle 16 shows busy=0, hi=lo=0, and no `done` follows.
- With `MUL_EARLY_EXIT_EN`: unsigned a=5, b=3 -> `done` in cycle 3, lo=15. b=0 -> `done` in cycle 2, hi=lo=0. Without the macro, both cases give `done` in cycle 33.
- WIDTH=8, signed: a=0x80, b=0xFF -> hi=0x00, lo=0x80 in cycle 9. Random signed/unsigned sweep of 10k vectors matched against a `$signed`/unsigned 2*WIDTH reference model.

Source files
------------

// File: rtl/iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : iter_mul
// Purpose  : Iterative shift-add multiplier for the execute-stage HI/LO unit.
//            Handles signed (MULT) and unsigned (MULTU) operands with one
//            datapath. Signed operands are converted to magnitudes, multiplied
//            unsigned one multiplier bit per cycle, and the 2*WIDTH product is
//            negated at the end if the operand signs differed.
// Ports    : clk        rising-edge clock
//            rst        synchronous active-high reset
//            start      request, sampled when idle or in the done cycle
//            is_signed  1 = two's-complement operands, sampled with start
//            a, b       multiplicand / multiplier, sampled with start
//            busy       high while iterating (registered)
//            done       one-cycle pulse, hi/lo valid (registered)
//            hi, lo     upper / lower half of the product, held until next done
// Options  : MUL_EARLY_EXIT_EN - finish as soon as the remaining multiplier
//            bits are all zero instead of always running WIDTH iterations.
// Revision : 1.0 - initial release
// ============================================================================
module iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               c_cnt_w = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;
    logic                 w_accept;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;
    logic [2*WIDTH-1:0]   w_product;
    logic                 w_last;

    // The most negative value negates to itself, which is exactly its
    // magnitude when read as unsigned, so no special case is needed.
    assign w_a_mag  = (is_signed && a[WIDTH-1]) ? (-a) : a;
    assign w_b_mag  = (is_signed && b[WIDTH-1]) ? (-b) : b;
    assign w_neg    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);

    // A new request is taken in IDLE and also in the DONE cycle (back-to-back).
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_sum = r_acc + w_addend;
    // Final sign fix-up uses this cycle's sum so the last partial product
    // is included.
    assign w_product = r_neg ? (-w_acc_sum) : w_acc_sum;

`ifdef MUL_EARLY_EXIT_EN
    // The accumulator is never shifted, so stopping once no multiplier bits
    // remain leaves the result unchanged.
    assign w_last = (r_cnt == c_last) || (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_last = (r_cnt == c_last);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (w_accept) begin
            r_state  <= S_BUSY;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_neg;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                S_BUSY: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_one;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        {hi, lo} <= w_product;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iter_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_mul
// Purpose  : Self-checking bench for iter_mul (WIDTH=32). Directed vector
//            table, multi-cycle corner sequences and a reference-model sweep.
//            Expected latency follows MUL_EARLY_EXIT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iter_mul;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    iter_mul #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic sgn, input logic [31:0] bv);
        logic [31:0] m;
        int h;
        m = (sgn && bv[31]) ? (-bv) : bv;
        h = 0;
        for (int i = 0; i < 32; i++) if (m[i]) h = i;
`ifdef MUL_EARLY_EXIT_EN
        return h + 2;
`else
        return (h < 0) ? 0 : W + 1;
`endif
    endfunction

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = {{32{av[31]}}, av};
            sb = {{32{bv[31]}}, bv};
            return sa * sb;
        end
        return {32'd0, av} * {32'd0, bv};
    endfunction

    // Drives a one-cycle start; returns one tick into cycle 1.
    task automatic launch(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk);
        #1;
        start = 1'b1; is_signed = sgn; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; is_signed = ~sgn;
    endtask

    // Samples at negedges starting in cycle n0; lat = cycle in which done seen.
    task automatic wait_done(input int n0, input string name, output int lat);
        int  n;
        logic bad;
        n   = n0;
        bad = 1'b0;
        lat = -1;
        while (n < 80) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) bad = 1'b1;
            n++;
        end
        check({name, "_busy_while_iter"}, {63'd0, bad}, 64'd0);
        if (lat >= 0) check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string name, input logic sgn, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
        int lat;
        launch(sgn, av, bv);
        wait_done(1, name, lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat(sgn, bv)));
        check({name, "_product"}, {hi, lo}, exp);
    endtask

    vec_t vecs[12];

    initial begin
        int lat;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{"u_ones",      1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"s_m1_x_1",    1'b1, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[2]  = '{"s_min_sq",    1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{"u_min_sq",    1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[4]  = '{"s_7_x_m3",    1'b1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[5]  = '{"u_5_x_3",     1'b0, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0000000F};
        vecs[6]  = '{"u_b_zero",    1'b0, 32'h00001234, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[7]  = '{"s_m1_sq",     1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8]  = '{"s_min_x_1",   1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[9]  = '{"u_2p16_sq",   1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{"s_neg2p16",   1'b1, 32'hFFFF0000, 32'h00010000, 32'hFFFFFFFF, 32'h00000000};
        vecs[11] = '{"s_3_x_max",   1'b1, 32'h00000003, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFD};

        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].av, vecs[i].bv, {vecs[i].ehi, vecs[i].elo});

        // Back-to-back: second start issued in the DONE cycle.
        launch(1'b1, 32'h7, 32'hFFFFFFFD);
        wait_done(1, "b2b_first", lat);
        check("b2b_first_latency", 64'(lat), 64'(exp_lat(1'b1, 32'hFFFFFFFD)));
        check("b2b_first_product", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        start = 1'b1; is_signed = 1'b0; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1, "b2b_second", lat);
        check("b2b_second_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd3)));
        check("b2b_second_product", {hi, lo}, 64'd6);
        repeat (3) @(negedge clk);
        check("done_single_pulse", {63'd0, done}, 64'd0);
        check("hilo_hold", {hi, lo}, 64'd6);

        // start pulsed during BUSY (cycle 10) must be ignored.
        launch(1'b0, 32'h3, 32'hFFFFFFFF);
        repeat (9) @(posedge clk);
        #1 start = 1'b1; is_signed = 1'b1; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(11, "busy_start", lat);
        check("busy_start_latency", 64'(lat), 64'(W + 1));
        check("busy_start_product", {hi, lo}, 64'h00000002_FFFFFFFD);

        // Reset in cycle 15 of an operation.
        launch(1'b0, 32'h9, 32'hFFFFFFFF);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        begin
            logic seen;
            seen = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done || busy) seen = 1'b1;
            end
            check("midrst_no_done", {63'd0, seen}, 64'd0);
        end

        // Reference-model sweep.
        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 1) rb = rb >> $urandom_range(0, 31);
            if (i % 7 == 2) ra = 32'h80000000;
            run_op("sweep", rs, ra, rb, model(rs, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
